// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer: divides clk into a periodic strobe and drives LED index / reload strobe.
// Optional LED_SEQ_FAST_SIM_EN forces the divider to 16 for short simulations.
module led_seq_ctrl #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_arg,
  output logic       delay_1s,
  output logic       led_load_en,
  output logic [1:0] led_sel,
  output logic       busy
);

`ifdef LED_SEQ_FAST_SIM_EN
  localparam int DIV = 16;
`else
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
`endif
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_HOLD   = 2'b01;
  localparam logic [1:0] OP_ROTATE = 2'b10;
  localparam logic [1:0] OP_RELOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_LOAD   = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic            r_phase;
  logic [1:0]      r_led_sel;
  logic            r_delay_1s;
  logic            r_led_load_en;
  logic            r_busy;

  state_t          w_state_next;
  logic [PW-1:0]   w_presc_next;
  logic            w_phase_next;
  logic [1:0]      w_led_sel_next;
  logic            w_delay_next;
  logic            w_load_next;
  logic            w_busy_next;
  logic            w_accept;
  logic            w_wrap;
  logic [1:0]      w_arg_clamped;

  // Ready is forced low while reset is asserted and rises with its release.
  assign cmd_ready     = rst_n && (r_state != ST_LOAD);
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_arg_clamped = (cmd_arg == 2'd3) ? 2'd2 : cmd_arg;
  assign w_wrap        = ((r_state == ST_HOLD) || (r_state == ST_ROTATE)) && (r_presc == PRESC_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_presc       <= '0;
      r_phase       <= 1'b0;
      r_led_sel     <= 2'd0;
      r_delay_1s    <= 1'b0;
      r_led_load_en <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_presc       <= w_presc_next;
      r_phase       <= w_phase_next;
      r_led_sel     <= w_led_sel_next;
      r_delay_1s    <= w_delay_next;
      r_led_load_en <= w_load_next;
      r_busy        <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_presc_next   = r_presc;
    w_phase_next   = r_phase;
    w_led_sel_next = r_led_sel;
    w_delay_next   = 1'b0;

    case (r_state)
      ST_HOLD, ST_ROTATE: begin
        w_presc_next = w_wrap ? '0 : r_presc + PW'(1);
        w_delay_next = w_wrap;
        // Phase/advance act on the registered strobe so led_sel moves one cycle after it.
        if ((r_state == ST_ROTATE) && r_delay_1s) begin
          w_phase_next = ~r_phase;
          if (r_phase) begin
            w_led_sel_next = (r_led_sel == 2'd2) ? 2'd0 : r_led_sel + 2'd1;
          end
        end
      end
      ST_LOAD: begin
        w_presc_next = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_presc_next = '0;
      end
    endcase

    // An accepted command overrides any wrap or advance in the same cycle.
    if (w_accept) begin
      w_presc_next = '0;
      w_delay_next = 1'b0;
      case (cmd_op)
        OP_STOP: begin
          w_state_next = ST_IDLE;
        end
        OP_HOLD: begin
          w_state_next   = ST_HOLD;
          w_led_sel_next = w_arg_clamped;
          w_phase_next   = 1'b0;
        end
        OP_ROTATE: begin
          w_state_next   = ST_ROTATE;
          w_led_sel_next = w_arg_clamped;
          w_phase_next   = 1'b0;
        end
        OP_RELOAD: begin
          w_state_next   = ST_LOAD;
          w_led_sel_next = 2'd0;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end

    w_load_next = (w_state_next == ST_LOAD);
    w_busy_next = (w_state_next == ST_HOLD) || (w_state_next == ST_ROTATE);
  end

  assign delay_1s    = r_delay_1s;
  assign led_load_en = r_led_load_en;
  assign led_sel     = r_led_sel;
  assign busy        = r_busy;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with a 16-cycle divider (CLK_FREQ_HZ=16, TICK_HZ=1).
module tb_led_seq_ctrl;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_HOLD   = 2'b01;
  localparam logic [1:0] OP_ROTATE = 2'b10;
  localparam logic [1:0] OP_RELOAD = 2'b11;
  localparam int DIV = 16;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_arg;
  logic       delay_1s;
  logic       led_load_en;
  logic [1:0] led_sel;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } strobe_t;

  strobe_t strobe_q[$];
  int      load_q[$];
  int      cyc;
  int      tests;
  int      fails;

  led_seq_ctrl #(
    .CLK_FREQ_HZ(16),
    .TICK_HZ    (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .delay_1s   (delay_1s),
    .led_load_en(led_load_en),
    .led_sel    (led_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every strobe / reload pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (delay_1s) begin
        tests++;
        if (strobe_q.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected cyc=%0d led_sel=%0d required=no strobe", cyc, led_sel);
        end else begin
          strobe_t e;
          e = strobe_q.pop_front();
          if (e.cyc != cyc || led_sel !== e.sel) begin
            fails++;
            $display("FAIL strobe cyc=%0d led_sel=%0d required cyc=%0d led_sel=%0d", cyc, led_sel, e.cyc, e.sel);
          end else begin
            $display("[TB] strobe cyc=%0d led_sel=%0d ok", cyc, led_sel);
          end
        end
      end
      if (led_load_en) begin
        tests++;
        if (load_q.size() == 0) begin
          fails++;
          $display("FAIL load_unexpected cyc=%0d required=no load", cyc);
        end else begin
          int ec;
          ec = load_q.pop_front();
          if (ec != cyc || cmd_ready !== 1'b0 || delay_1s !== 1'b0) begin
            fails++;
            $display("FAIL load cyc=%0d ready=%0b strobe=%0b required cyc=%0d ready=0 strobe=0", cyc, cmd_ready, delay_1s, ec);
          end else begin
            $display("[TB] load cyc=%0d ok", cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the following negedge with acc = cycle index of the accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] arg, output int acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("[TB] cmd op=%0d arg=%0d accepted cyc=%0d", op, arg, acc);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = 2'b00;
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_ready, delay_1s, led_load_en, led_sel, busy} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b required=000000", {cmd_ready, delay_1s, led_load_en, led_sel, busy});
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || led_sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_release ready=%0b busy=%0b sel=%0d required 1 0 0", cmd_ready, busy, led_sel);
    end
    $display("[TB] reset done cyc=%0d", cyc);
    @(negedge clk);
  endtask

  task automatic test_hold();
    int acc, acc_s;
    send_cmd(OP_HOLD, 2'd1, acc);
    for (int i = 1; i <= 4; i++) strobe_q.push_back('{acc + i * DIV, 2'd1});
    tests++;
    if (busy !== 1'b1 || led_sel !== 2'd1) begin
      fails++;
      $display("FAIL hold_state busy=%0b sel=%0d required 1 1", busy, led_sel);
    end
    wait_until(acc + 4 * DIV + 2);
    tests++;
    if (led_sel !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hold_stable busy=%0b sel=%0d required 1 1", busy, led_sel);
    end
    send_cmd(OP_STOP, 2'd0, acc_s);
    tests++;
    if (busy !== 1'b0 || led_sel !== 2'd1) begin
      fails++;
      $display("FAIL stop_retain busy=%0b sel=%0d required 0 1", busy, led_sel);
    end
    wait_until(acc_s + 3 * DIV);
    tests++;
    if (strobe_q.size() != 0) begin
      fails++;
      $display("FAIL hold_missing_strobes pending=%0d required=0", strobe_q.size());
      strobe_q.delete();
    end
  endtask

  task automatic test_hold_clamp();
    int acc, acc_s;
    send_cmd(OP_HOLD, 2'd3, acc);
    for (int i = 1; i <= 2; i++) strobe_q.push_back('{acc + i * DIV, 2'd2});
    tests++;
    if (led_sel !== 2'd2) begin
      fails++;
      $display("FAIL hold_clamp sel=%0d required=2", led_sel);
    end
    wait_until(acc + 2 * DIV + 2);
    send_cmd(OP_STOP, 2'd0, acc_s);
    wait_until(acc_s + 2 * DIV);
    tests++;
    if (strobe_q.size() != 0) begin
      fails++;
      $display("FAIL clamp_missing_strobes pending=%0d required=0", strobe_q.size());
      strobe_q.delete();
    end
  endtask

  task automatic test_rotate();
    int acc, acc_s;
    logic [1:0] seq [7];
    seq = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    send_cmd(OP_ROTATE, 2'd2, acc);
    for (int i = 0; i < 7; i++) strobe_q.push_back('{acc + (i + 1) * DIV, seq[i]});
    wait_until(acc + 2 * DIV);
    tests++;
    if (led_sel !== 2'd2) begin
      fails++;
      $display("FAIL rotate_before_advance sel=%0d required=2", led_sel);
    end
    @(negedge clk);
    tests++;
    if (led_sel !== 2'd0) begin
      fails++;
      $display("FAIL rotate_after_advance sel=%0d required=0", led_sel);
    end
    wait_until(acc + 7 * DIV + 1);
    send_cmd(OP_STOP, 2'd0, acc_s);
    wait_until(acc_s + 2 * DIV);
    tests++;
    if (strobe_q.size() != 0) begin
      fails++;
      $display("FAIL rotate_missing_strobes pending=%0d required=0", strobe_q.size());
      strobe_q.delete();
    end
  endtask

  task automatic test_reload();
    int acc, acc_l;
    send_cmd(OP_ROTATE, 2'd1, acc);
    strobe_q.push_back('{acc + DIV, 2'd1});
    wait_until(acc + DIV + 4);
    load_q.push_back(cyc + 1);
    send_cmd(OP_RELOAD, 2'd2, acc_l);
    tests++;
    if (led_sel !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reload_load_cycle sel=%0d busy=%0b required 0 0", led_sel, busy);
    end
    @(negedge clk);
    tests++;
    if (led_load_en !== 1'b0 || cmd_ready !== 1'b1 || led_sel !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reload_idle load=%0b ready=%0b sel=%0d busy=%0b required 0 1 0 0", led_load_en, cmd_ready, led_sel, busy);
    end
    wait_until(acc_l + 3 * DIV);
    tests++;
    if (strobe_q.size() != 0 || load_q.size() != 0) begin
      fails++;
      $display("FAIL reload_pending strobes=%0d loads=%0d required 0 0", strobe_q.size(), load_q.size());
      strobe_q.delete();
      load_q.delete();
    end
  endtask

  task automatic test_collision();
    int acc, acc2, acc_s;
    send_cmd(OP_HOLD, 2'd0, acc);
    wait_until(acc + DIV - 1);
    send_cmd(OP_HOLD, 2'd2, acc2);
    tests++;
    if (acc2 != acc + DIV) begin
      fails++;
      $display("FAIL collision_accept_cycle cyc=%0d required=%0d", acc2, acc + DIV);
    end
    strobe_q.push_back('{acc2 + DIV, 2'd2});
    strobe_q.push_back('{acc2 + 2 * DIV, 2'd2});
    wait_until(acc2 + 2 * DIV + 2);
    send_cmd(OP_STOP, 2'd0, acc_s);
    wait_until(acc_s + 2 * DIV);
    tests++;
    if (strobe_q.size() != 0) begin
      fails++;
      $display("FAIL collision_missing_strobes pending=%0d required=0", strobe_q.size());
      strobe_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, acc_s;
    send_cmd(OP_HOLD, 2'd1, acc1);
    send_cmd(OP_ROTATE, 2'd0, acc2);
    strobe_q.push_back('{acc2 + DIV, 2'd0});
    strobe_q.push_back('{acc2 + 2 * DIV, 2'd0});
    tests++;
    if (led_sel !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_state sel=%0d busy=%0b required 0 1", led_sel, busy);
    end
    wait_until(acc2 + 2 * DIV + 2);
    tests++;
    if (led_sel !== 2'd1) begin
      fails++;
      $display("FAIL b2b_advance sel=%0d required=1", led_sel);
    end
    send_cmd(OP_STOP, 2'd0, acc_s);
    wait_until(acc_s + 2 * DIV);
    tests++;
    if (strobe_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_missing_strobes pending=%0d required=0", strobe_q.size());
      strobe_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int acc, rel;
    send_cmd(OP_ROTATE, 2'd0, acc);
    strobe_q.push_back('{acc + DIV, 2'd0});
    strobe_q.push_back('{acc + 2 * DIV, 2'd0});
    wait_until(acc + 2 * DIV + 8);
    tests++;
    if (led_sel !== 2'd1) begin
      fails++;
      $display("FAIL reset_mid_pre sel=%0d required=1", led_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, delay_1s, led_load_en, led_sel, busy} !== 6'b0) begin
      fails++;
      $display("FAIL reset_mid_async got=%b required=000000", {cmd_ready, delay_1s, led_load_en, led_sel, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    wait_until(rel + 64);
    tests++;
    if (busy !== 1'b0 || led_sel !== 2'd0 || strobe_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_idle busy=%0b sel=%0d pending=%0d required 0 0 0", busy, led_sel, strobe_q.size());
      strobe_q.delete();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_hold();
    test_hold_clamp();
    test_rotate();
    test_reload();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
